// File: rtl/conv_pkg.sv
// Shared FSM encodings and width/saturation helpers for the streaming 2-D convolution engine.
// Widths derive from MAX_DIM/DATA_W so the top and MAC unit always agree.
package conv_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_LOAD_IMG = 3'd1;
    localparam logic [2:0] ST_LOAD_KER = 3'd2;
    localparam logic [2:0] ST_MAC      = 3'd3;
    localparam logic [2:0] ST_OUT      = 3'd4;

    function automatic int dimW(input int maxDim);
        return $clog2(maxDim + 1);
    endfunction

    function automatic int idxW(input int maxDim);
        return (maxDim > 1) ? $clog2(maxDim * maxDim) : 1;
    endfunction

    function automatic int accW(input int dataW, input int maxDim);
        return 2 * dataW + $clog2(maxDim * maxDim);
    endfunction

    // Bounds as 64-bit two's complement; callers truncate to their accumulator width.
    function automatic longint satHi(input int outW, input int sgn);
        return (sgn != 0) ? (64'sd1 <<< (outW - 1)) - 64'sd1 : (64'sd1 <<< outW) - 64'sd1;
    endfunction

    function automatic longint satLo(input int outW, input int sgn);
        return (sgn != 0) ? -(64'sd1 <<< (outW - 1)) : 64'sd0;
    endfunction

endpackage

// File: rtl/conv_mac.sv
// Multiply-accumulate unit: one product per enabled cycle into a non-wrapping accumulator.
// Saturated result is combinational from the accumulator; clear has priority over enable.
module conv_mac
    import conv_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int OUT_W   = 16,
    parameter int MAX_DIM = 16,
    parameter int SIGNED  = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [OUT_W-1:0]  sat
);

    localparam int ACC_W = accW(DATA_W, MAX_DIM);
    localparam logic [ACC_W-1:0] HI = ACC_W'(satHi(OUT_W, SIGNED));
    localparam logic [ACC_W-1:0] LO = ACC_W'(satLo(OUT_W, SIGNED));

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] aExt;
    logic [ACC_W-1:0] bExt;
    logic [ACC_W-1:0] prod;

    // Low ACC_W bits of the product are exact for both signednesses once operands are extended.
    always_comb begin
        if (SIGNED != 0) begin
            aExt = {{(ACC_W-DATA_W){a[DATA_W-1]}}, a};
            bExt = {{(ACC_W-DATA_W){b[DATA_W-1]}}, b};
        end else begin
            aExt = {{(ACC_W-DATA_W){1'b0}}, a};
            bExt = {{(ACC_W-DATA_W){1'b0}}, b};
        end
        prod = aExt * bExt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + prod;
        end
    end

    always_comb begin
        sat = acc[OUT_W-1:0];
        if (SIGNED != 0) begin
            if ($signed(acc) > $signed(HI)) begin
                sat = HI[OUT_W-1:0];
            end else if ($signed(acc) < $signed(LO)) begin
                sat = LO[OUT_W-1:0];
            end
        end else if (acc > HI) begin
            sat = HI[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/conv2d_stream.sv
// Streaming valid-mode 2-D convolution: load image, load kernel, one MAC/cycle; first result KR*KC+1 cycles after last kernel beat.
// Results held stable while out_ready is low and no compute proceeds during the stall.
module conv2d_stream
    import conv_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int OUT_W   = 16,
    parameter int MAX_DIM = 16,
    parameter int SIGNED  = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cfg_start,
    input  logic [dimW(MAX_DIM)-1:0]   cfg_img_rows,
    input  logic [dimW(MAX_DIM)-1:0]   cfg_img_cols,
    input  logic [dimW(MAX_DIM)-1:0]   cfg_ker_rows,
    input  logic [dimW(MAX_DIM)-1:0]   cfg_ker_cols,
    input  logic [1:0]                 cfg_stride,
    input  logic                       img_valid,
    output logic                       img_ready,
    input  logic [DATA_W-1:0]          img_data,
    input  logic                       ker_valid,
    output logic                       ker_ready,
    input  logic [DATA_W-1:0]          ker_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [OUT_W-1:0]           out_data,
    output logic                       out_last,
    output logic                       busy,
    output logic                       cfg_err
);

    localparam int DW = dimW(MAX_DIM);
    localparam int IW = idxW(MAX_DIM);
    localparam int CW = 2 * DW;
    localparam int PW = DW + 2;

    logic [2:0]        state;
    logic [DW-1:0]     rows, cols, kRows, kCols;
    logic [1:0]        stride;
    logic [CW-1:0]     loadCnt;
    logic [DW-1:0]     kIdx, lIdx, oRow, oCol;
    logic              macDone;
    logic [DATA_W-1:0] imgBuf [MAX_DIM*MAX_DIM];
    logic [DATA_W-1:0] kerBuf [MAX_DIM*MAX_DIM];

    logic          cfgBad, startOk, imgHs, kerHs, macEn, macClr;
    logic          lastL, lastK, lastCol, lastRow;
    logic [CW-1:0] imgTotal, kerTotal;
    logic [IW-1:0] imgAddr, kerAddr;
    logic [OUT_W-1:0] satOut;

    always_comb begin
        cfgBad = (cfg_img_rows == '0) || (cfg_img_cols == '0) || (cfg_ker_rows == '0) ||
                 (cfg_ker_cols == '0) || (cfg_ker_rows > cfg_img_rows) ||
                 (cfg_ker_cols > cfg_img_cols) || (cfg_img_rows > DW'(MAX_DIM)) ||
                 (cfg_img_cols > DW'(MAX_DIM)) || (cfg_stride == 2'd0);
        startOk  = (state == ST_IDLE) && cfg_start && !cfgBad;
        imgHs    = img_valid && img_ready;
        kerHs    = ker_valid && ker_ready;
        imgTotal = CW'(rows) * CW'(cols);
        kerTotal = CW'(kRows) * CW'(kCols);
        imgAddr  = IW'((CW'(oRow) + CW'(kIdx)) * CW'(cols) + CW'(oCol) + CW'(lIdx));
        kerAddr  = IW'(CW'(kIdx) * CW'(kCols) + CW'(lIdx));
        lastL    = (lIdx == kCols - DW'(1));
        lastK    = (kIdx == kRows - DW'(1));
        // A window is the last in its row/column when one more stride would run off the image.
        lastCol  = (PW'(oCol) + PW'(stride) + PW'(kCols)) > PW'(cols);
        lastRow  = (PW'(oRow) + PW'(stride) + PW'(kRows)) > PW'(rows);
        macEn    = (state == ST_MAC) && !macDone;
        macClr   = startOk || ((state == ST_OUT) && out_ready);
    end

    assign img_ready = (state == ST_LOAD_IMG);
    assign ker_ready = (state == ST_LOAD_KER);
    assign busy      = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (imgHs) imgBuf[loadCnt[IW-1:0]] <= img_data;
        if (kerHs) kerBuf[loadCnt[IW-1:0]] <= ker_data;
    end

    conv_mac #(
        .DATA_W (DATA_W),
        .OUT_W  (OUT_W),
        .MAX_DIM(MAX_DIM),
        .SIGNED (SIGNED)
    ) u_mac (
        .clk(clk),
        .rst(rst),
        .clr(macClr),
        .en (macEn),
        .a  (imgBuf[imgAddr]),
        .b  (kerBuf[kerAddr]),
        .sat(satOut)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            rows      <= '0;
            cols      <= '0;
            kRows     <= '0;
            kCols     <= '0;
            stride    <= '0;
            loadCnt   <= '0;
            kIdx      <= '0;
            lIdx      <= '0;
            oRow      <= '0;
            oCol      <= '0;
            macDone   <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            cfg_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cfg_start && cfgBad) begin
                        cfg_err <= 1'b1;
                    end else if (startOk) begin
                        rows    <= cfg_img_rows;
                        cols    <= cfg_img_cols;
                        kRows   <= cfg_ker_rows;
                        kCols   <= cfg_ker_cols;
                        stride  <= cfg_stride;
                        loadCnt <= '0;
                        state   <= ST_LOAD_IMG;
                    end
                end
                ST_LOAD_IMG: begin
                    if (imgHs) begin
                        if (loadCnt == imgTotal - CW'(1)) begin
                            loadCnt <= '0;
                            state   <= ST_LOAD_KER;
                        end else begin
                            loadCnt <= loadCnt + CW'(1);
                        end
                    end
                end
                ST_LOAD_KER: begin
                    if (kerHs) begin
                        if (loadCnt == kerTotal - CW'(1)) begin
                            loadCnt <= '0;
                            kIdx    <= '0;
                            lIdx    <= '0;
                            oRow    <= '0;
                            oCol    <= '0;
                            macDone <= 1'b0;
                            state   <= ST_MAC;
                        end else begin
                            loadCnt <= loadCnt + CW'(1);
                        end
                    end
                end
                ST_MAC: begin
                    // Extra cycle after the final product lets the accumulator settle before registering.
                    if (macDone) begin
                        out_data  <= satOut;
                        out_valid <= 1'b1;
                        out_last  <= lastRow && lastCol;
                        macDone   <= 1'b0;
                        state     <= ST_OUT;
                    end else if (lastL) begin
                        lIdx <= '0;
                        if (lastK) begin
                            kIdx    <= '0;
                            macDone <= 1'b1;
                        end else begin
                            kIdx <= kIdx + DW'(1);
                        end
                    end else begin
                        lIdx <= lIdx + DW'(1);
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        if (out_last) begin
                            state <= ST_IDLE;
                        end else begin
                            state <= ST_MAC;
                            if (lastCol) begin
                                oCol <= '0;
                                oRow <= oRow + DW'(stride);
                            end else begin
                                oCol <= oCol + DW'(stride);
                            end
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv2d_stream.sv
// Scoreboarded bench: an unsigned and a signed instance share stimulus, selected by sel.
// Expected results come from a direct window-sum model; a negedge monitor pops and compares.
module tb_conv2d_stream;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       sel = 1'b0;
    logic       cfg_start = 1'b0;
    logic [4:0] cfgR = '0, cfgC = '0, cfgKR = '0, cfgKC = '0;
    logic [1:0] cfgS = '0;
    logic       img_valid = 1'b0, ker_valid = 1'b0;
    logic [7:0] img_data = '0, ker_data = '0;
    logic       out_ready;

    logic        uImgRdy, uKerRdy, uOutVld, uOutLast, uBusy, uCfgErr;
    logic [15:0] uOutDat;
    logic        sImgRdy, sKerRdy, sOutVld, sOutLast, sBusy, sCfgErr;
    logic [7:0]  sOutDat;

    conv2d_stream #(.DATA_W(8), .OUT_W(16), .MAX_DIM(16), .SIGNED(0)) dutU (
        .clk(clk), .rst(rst), .cfg_start(cfg_start && !sel),
        .cfg_img_rows(cfgR), .cfg_img_cols(cfgC), .cfg_ker_rows(cfgKR), .cfg_ker_cols(cfgKC),
        .cfg_stride(cfgS),
        .img_valid(img_valid), .img_ready(uImgRdy), .img_data(img_data),
        .ker_valid(ker_valid), .ker_ready(uKerRdy), .ker_data(ker_data),
        .out_valid(uOutVld), .out_ready(out_ready), .out_data(uOutDat), .out_last(uOutLast),
        .busy(uBusy), .cfg_err(uCfgErr)
    );

    conv2d_stream #(.DATA_W(8), .OUT_W(8), .MAX_DIM(4), .SIGNED(1)) dutS (
        .clk(clk), .rst(rst), .cfg_start(cfg_start && sel),
        .cfg_img_rows(cfgR[2:0]), .cfg_img_cols(cfgC[2:0]), .cfg_ker_rows(cfgKR[2:0]),
        .cfg_ker_cols(cfgKC[2:0]), .cfg_stride(cfgS),
        .img_valid(img_valid), .img_ready(sImgRdy), .img_data(img_data),
        .ker_valid(ker_valid), .ker_ready(sKerRdy), .ker_data(ker_data),
        .out_valid(sOutVld), .out_ready(out_ready), .out_data(sOutDat), .out_last(sOutLast),
        .busy(sBusy), .cfg_err(sCfgErr)
    );

    wire        imgReady = sel ? sImgRdy  : uImgRdy;
    wire        kerReady = sel ? sKerRdy  : uKerRdy;
    wire        outValid = sel ? sOutVld  : uOutVld;
    wire        outLast  = sel ? sOutLast : uOutLast;
    wire        busyW    = sel ? sBusy    : uBusy;
    wire        cfgErrW  = sel ? sCfgErr  : uCfgErr;
    wire [15:0] outData  = sel ? {{8{sOutDat[7]}}, sOutDat} : uOutDat;

    int checks = 0;
    int errors = 0;

    task automatic check(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [15:0] dat;
        logic        last;
    } exp_t;
    exp_t expQ[$];

    // Response ready pattern: 0 always ready, 1 ready one cycle in three, 2 random.
    int readyMode = 0;
    int rdyCnt = 0;
    always @(posedge clk) begin
        #1;
        case (readyMode)
            0: out_ready = 1'b1;
            1: begin out_ready = (rdyCnt % 3 == 0); rdyCnt++; end
            default: out_ready = ($urandom_range(0, 9) < 6);
        endcase
    end

    logic        stalled = 1'b0;
    logic [15:0] heldDat;
    logic        heldLast;
    exp_t        e;

    always @(negedge clk) begin
        if (rst) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                check("hold_valid", outValid, 1);
                if (outValid) begin
                    check("hold_data", outData, heldDat);
                    check("hold_last", outLast, heldLast);
                end
            end
            stalled = 1'b0;
            if (outValid) begin
                if (out_ready) begin
                    if (expQ.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_out: got data %0d with empty scoreboard", outData);
                    end else begin
                        e = expQ.pop_front();
                        check("out_data", outData, e.dat);
                        check("out_last", outLast, e.last);
                    end
                end else begin
                    stalled  = 1'b1;
                    heldDat  = outData;
                    heldLast = outLast;
                end
            end
        end
    end

    int  imgA[256];
    int  kerA[256];
    int  fR, fC, fKR, fKC, fS;
    bit  gaps = 1'b0;

    task automatic buildExpected(input bit sgn);
        int oR, oC;
        longint acc, hi, lo;
        exp_t x;
        oR = (fR - fKR) / fS + 1;
        oC = (fC - fKC) / fS + 1;
        hi = sgn ? 127 : 65535;
        lo = sgn ? -128 : 0;
        for (int oi = 0; oi < oR; oi++) begin
            for (int oj = 0; oj < oC; oj++) begin
                acc = 0;
                for (int k = 0; k < fKR; k++)
                    for (int l = 0; l < fKC; l++)
                        acc += longint'(imgA[(oi*fS + k)*fC + oj*fS + l]) * kerA[k*fKC + l];
                if (acc > hi) acc = hi;
                if (acc < lo) acc = lo;
                x.dat  = 16'(acc);
                x.last = (oi == oR - 1) && (oj == oC - 1);
                expQ.push_back(x);
            end
        end
    endtask

    task automatic sendSample(input bit isKer, input logic [7:0] d);
        int guard;
        if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        if (isKer) begin ker_valid = 1'b1; ker_data = d; end
        else begin img_valid = 1'b1; img_data = d; end
        guard = 0;
        forever begin
            @(negedge clk);
            if (isKer ? kerReady : imgReady) break;
            guard++;
            if (guard > 100) begin
                checks++;
                errors++;
                $display("FAIL stream_accept: ready low for %0d cycles", guard);
                break;
            end
        end
        @(posedge clk); #1;
        img_valid = 1'b0;
        ker_valid = 1'b0;
    endtask

    task automatic pulseCfg(input int r, input int c, input int kr, input int kc, input int s);
        cfgR = 5'(r); cfgC = 5'(c); cfgKR = 5'(kr); cfgKC = 5'(kc); cfgS = 2'(s);
        cfg_start = 1'b1;
        @(posedge clk); #1;
        cfg_start = 1'b0;
    endtask

    task automatic runFrame(input bit sgn, input bit abortMid);
        int lat, guard;
        sel = sgn;
        buildExpected(sgn);
        pulseCfg(fR, fC, fKR, fKC, fS);
        check("busy_after_start", busyW, 1);
        pulseCfg(fR, fC, 0, fKC, 0);
        check("start_while_busy_no_err", cfgErrW, 0);
        for (int i = 0; i < fR*fC; i++) sendSample(1'b0, 8'(imgA[i]));
        for (int i = 0; i < fKR*fKC; i++) sendSample(1'b1, 8'(kerA[i]));
        if (abortMid) begin
            repeat (2) @(posedge clk);
            #1;
            rst = 1'b1;
            #1;
            check("abort_out_valid", outValid, 0);
            check("abort_busy", busyW, 0);
            expQ.delete();
            @(posedge clk); #1;
            rst = 1'b0;
            return;
        end
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!outValid && lat < 2000);
        check("first_latency", lat, fKR*fKC + 1);
        guard = 0;
        while (busyW && guard < 20000) begin
            @(posedge clk); #1;
            guard++;
        end
        check("frame_done_in_time", busyW, 0);
        check("scoreboard_drained", expQ.size(), 0);
        check("idle_out_valid", outValid, 0);
    endtask

    task automatic badCfg(input int r, input int c, input int kr, input int kc, input int s);
        pulseCfg(r, c, kr, kc, s);
        check("cfg_err_pulse", cfgErrW, 1);
        check("cfg_err_busy", busyW, 0);
        check("cfg_err_img_ready", imgReady, 0);
        @(posedge clk); #1;
        check("cfg_err_one_cycle", cfgErrW, 0);
        check("cfg_err_still_idle", imgReady, 0);
    endtask

    task automatic setTest1();
        fR = 3; fC = 3; fKR = 2; fKC = 2; fS = 1;
        for (int i = 0; i < 9; i++) imgA[i] = i + 1;
        for (int i = 0; i < 4; i++) kerA[i] = 1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", outValid, 0);
        check("rst_out_last", outLast, 0);
        check("rst_out_data", outData, 0);
        check("rst_busy", busyW, 0);
        check("rst_cfg_err", cfgErrW, 0);
        check("rst_img_ready", imgReady, 0);
        check("rst_ker_ready", kerReady, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        setTest1();
        runFrame(1'b0, 1'b0);

        fR = 4; fC = 4; fKR = 2; fKC = 2; fS = 2;
        for (int i = 0; i < 16; i++) imgA[i] = i + 1;
        kerA[0] = 1; kerA[1] = 0; kerA[2] = 0; kerA[3] = 1;
        runFrame(1'b0, 1'b0);

        readyMode = 1;
        setTest1();
        runFrame(1'b0, 1'b0);
        readyMode = 0;

        fR = 2; fC = 2; fKR = 2; fKC = 2; fS = 1;
        for (int i = 0; i < 4; i++) begin imgA[i] = 127; kerA[i] = 127; end
        runFrame(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin imgA[i] = -128; kerA[i] = 127; end
        runFrame(1'b1, 1'b0);
        sel = 1'b0;

        badCfg(3, 3, 4, 2, 1);
        badCfg(3, 3, 2, 4, 1);
        badCfg(3, 3, 0, 2, 1);
        badCfg(3, 3, 2, 2, 0);
        badCfg(17, 3, 2, 2, 1);

        setTest1();
        runFrame(1'b0, 1'b1);
        check("post_abort_idle", busyW, 0);
        setTest1();
        runFrame(1'b0, 1'b0);

        fR = 16; fC = 16; fKR = 16; fKC = 16; fS = 1;
        for (int i = 0; i < 256; i++) begin imgA[i] = 255; kerA[i] = 255; end
        runFrame(1'b0, 1'b0);

        gaps = 1'b1;
        readyMode = 2;
        for (int t = 0; t < 12; t++) begin
            fR  = $urandom_range(1, 8);
            fC  = $urandom_range(1, 8);
            fKR = $urandom_range(1, fR);
            fKC = $urandom_range(1, fC);
            fS  = $urandom_range(1, 3);
            for (int i = 0; i < fR*fC; i++) imgA[i] = $urandom_range(0, 255);
            for (int i = 0; i < fKR*fKC; i++) kerA[i] = $urandom_range(0, 255);
            runFrame(1'b0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
